// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell based sequential blocks.
package jk_pkg;

  // J/K drive encodings, packed as {J, K}.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Highest count value of a mod-N counter.
  function automatic int terminal_value(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/jk_ff_sync_reset.sv
// Single JK flip-flop cell with synchronous active-high reset.
module jk_ff_sync_reset
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  // Next-state decode of the J/K pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    q_d = q_q;
    case ({j, k})
      JK_CLR:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // State register; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Mod-N up/down counter built from one JK cell per bit, with parallel
// load, terminal-count and wrap / load-error flags.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] TERM    = WIDTH'(terminal_value(MODULUS));
  // One extra bit so MODULUS == 2**WIDTH is representable in compares.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0]      q_cells;
  logic [WIDTH-1:0]      unused_qb;
  logic [WIDTH-1:0][1:0] jk_d;
  logic                  wrap_d, wrap_q;
  logic                  load_err_d, load_err_q;

  // Next-value decode: load and wrap drive set/clear onto every bit,
  // ordinary steps toggle the bits whose lower bits are all 1 (up) / all 0 (down).
  always_comb begin
    logic [WIDTH-1:0] target;
    logic             in_range;
    logic             wrap_step;
    logic             carry;

    jk_d       = '0;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    target     = '0;
    wrap_step  = 1'b0;
    carry      = 1'b1;
    in_range   = ({1'b0, q_cells} < MOD_EXT);

    if (load) begin
      if ({1'b0, din} < MOD_EXT) begin
        target = din;
      end else begin
        target     = TERM;
        load_err_d = 1'b1;
      end
      for (int i = 0; i < WIDTH; i++) jk_d[i] = target[i] ? JK_SET : JK_CLR;
    end else if (en) begin
      if (up) begin
        wrap_step = !in_range || (q_cells == TERM);
        target    = '0;
      end else begin
        wrap_step = !in_range || (q_cells == '0);
        target    = TERM;
      end
      if (wrap_step) begin
        wrap_d = 1'b1;
        for (int i = 0; i < WIDTH; i++) jk_d[i] = target[i] ? JK_SET : JK_CLR;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          jk_d[i] = carry ? JK_TGL : JK_HOLD;
          carry   = carry & (up ? q_cells[i] : ~q_cells[i]);
        end
      end
    end
  end

  // One JK cell per counter bit; reset goes straight to the cells.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_ff_sync_reset u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (jk_d[gi][1]),
      .k     (jk_d[gi][0]),
      .q     (q_cells[gi]),
      .qb    (unused_qb[gi])
    );
  end

  // One-cycle flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_cells;
  assign tc       = en & ((up & (q_cells == TERM)) | (~up & (q_cells == '0)));
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench for jk_updown_counter: a mod-10 instance and a mod-16 instance.
module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc, wrap, load_err;

  logic       b_reset, b_en, b_up, b_load;
  logic [3:0] b_din;
  logic [3:0] b_q;
  logic       b_tc, b_wrap, b_load_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(b_reset), .en(b_en), .up(b_up), .load(b_load), .din(b_din),
    .q(b_q), .tc(b_tc), .wrap(b_wrap), .load_err(b_load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] eq, input logic ew,
                             input logic ele, input logic etc);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    check({tag, ".load_err"}, 32'(load_err), 32'(ele));
    check({tag, ".tc"}, 32'(tc), 32'(etc));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; en = 0; up = 1; load = 0; din = 0;
    b_reset = 1; b_en = 0; b_up = 1; b_load = 0; b_din = 0;
    #2;

    // Reset, then count up through the wrap.
    tick(); tick();
    check_state("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 0; en = 1; up = 1;
    #1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_state($sformatf("up%0d", i), 4'(i % 10), (i == 10), 1'b0, ((i % 10) == 9));
    end

    // Reset, then count down through the wrap.
    reset = 1; tick(); tick();
    reset = 0; en = 1; up = 0;
    #1;
    check_state("down0", 4'd0, 1'b0, 1'b0, 1'b1);
    tick(); check_state("down1", 4'd9, 1'b1, 1'b0, 1'b0);
    tick(); check_state("down2", 4'd8, 1'b0, 1'b0, 1'b0);

    // Loads: in range, count after, out of range, flag drops.
    en = 0; up = 1; load = 1; din = 4'd7;
    tick(); check_state("load7", 4'd7, 1'b0, 1'b0, 1'b0);
    load = 0; en = 1;
    tick(); check_state("load7_inc", 4'd8, 1'b0, 1'b0, 1'b0);
    en = 0; load = 1; din = 4'd12;
    tick(); check_state("load12", 4'd9, 1'b0, 1'b1, 1'b0);
    load = 0;
    tick(); check_state("load12_after", 4'd9, 1'b0, 1'b0, 1'b0);

    // Load at the terminal value with en asserted: load wins, no wrap.
    load = 1; en = 1; up = 1; din = 4'd3;
    tick(); check_state("load_at_tc", 4'd3, 1'b0, 1'b0, 1'b0);

    // Load and en together from q=5, then hold.
    load = 1; en = 0; din = 4'd5;
    tick();
    load = 1; en = 1; up = 1; din = 4'd2;
    tick(); check_state("load_en", 4'd2, 1'b0, 1'b0, 1'b0);
    load = 0; en = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_state($sformatf("hold%0d", i), 4'd2, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-count overrides load and en; counting resumes afterwards.
    load = 1; din = 4'd4;
    tick();
    load = 0; en = 1; up = 1;
    tick(); tick();
    check_state("pre_reset", 4'd6, 1'b0, 1'b0, 1'b0);
    reset = 1; load = 1; din = 4'd3;
    tick(); check({"midreset", ".q"}, 32'(q), 32'd0);
    check("midreset.wrap", 32'(wrap), 32'd0);
    check("midreset.load_err", 32'(load_err), 32'd0);
    reset = 0; load = 0;
    tick(); check_state("resume1", 4'd1, 1'b0, 1'b0, 1'b0);
    tick(); check_state("resume2", 4'd2, 1'b0, 1'b0, 1'b0);

    // Full-range counter: wrap in both directions with up toggled each cycle.
    tick();
    b_reset = 0; b_load = 1; b_din = 4'd15;
    tick(); check("m16.load15", 32'(b_q), 32'd15);
    b_load = 0; b_en = 1; b_up = 1;
    #1; check("m16.tc_up", 32'(b_tc), 32'd1);
    tick(); check("m16.q_up", 32'(b_q), 32'd0);
    check("m16.wrap_up", 32'(b_wrap), 32'd1);
    b_up = 0;
    #1; check("m16.tc_down", 32'(b_tc), 32'd1);
    tick(); check("m16.q_down", 32'(b_q), 32'd15);
    check("m16.wrap_down", 32'(b_wrap), 32'd1);
    b_up = 1;
    tick(); check("m16.q_up2", 32'(b_q), 32'd0);
    check("m16.wrap_up2", 32'(b_wrap), 32'd1);
    b_en = 0;
    tick(); check("m16.wrap_clear", 32'(b_wrap), 32'd0);
    check("m16.load_err", 32'(b_load_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
